// File: rtl/board_engine.sv
// board_engine
//   Connect Four board owner on the responder side of the move interface.
//   Accepts one move at a time, drops the piece into the requested column,
//   scans the four line directions through the placed piece and returns a
//   one-cycle result. A combinational read port serves the display path.
//
// Parameters
//   ROWS (<=8, row 0 is the bottom), COLS (<=8)
//
// Ports
//   clk, reset            clock; asynchronous active-high reset
//   move_valid/move_ready request handshake (ready only while idle)
//   column, player        move target column; 1 = player 1, 0 = player 2
//   result_valid          one-cycle pulse closing each accepted handshake
//   move_accepted         0 when the column is full or out of range
//   win, winner           sticky win flag and winner code (01 P1, 10 P2)
//   board_full            sticky draw flag
//   rd_row, rd_col        display read address
//   rd_cell               cell contents (00 empty, 01 P1, 10 P2)
//
// Build option
//   BOARD_ENGINE_FAST_CHECK_EN: evaluate all four directions in a single
//   CHECK cycle instead of one direction per cycle.

module board_engine #(
    parameter int ROWS = 6,
    parameter int COLS = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       move_valid,
    output logic       move_ready,
    input  logic [2:0] column,
    input  logic       player,
    output logic       result_valid,
    output logic       move_accepted,
    output logic       win,
    output logic [1:0] winner,
    output logic       board_full,
    input  logic [2:0] rd_row,
    input  logic [2:0] rd_col,
    output logic [1:0] rd_cell
);

    localparam int CELLS = ROWS * COLS;
    localparam int BW    = CELLS * 2;
    localparam int CW    = $clog2(CELLS + 1);

    typedef enum logic [2:0] {IDLE, DROP, CHECK, DONE, OVER} state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     board_q, board_d;
    logic [COLS*4-1:0] height_q, height_d;
    logic [CW-1:0]     moves_q, moves_d;
    logic [2:0]        col_q, col_d;
    logic [2:0]        row_q, row_d;
    logic              player_q, player_d;
    logic              acc_q, acc_d;
    logic              hit_q, hit_d;
    logic [1:0]        dir_q, dir_d;
    logic              win_q, win_d;
    logic [1:0]        winner_q, winner_d;
    logic              full_q, full_d;

    logic [1:0]        code;
    logic [3:0]        dir_hit;
    logic [3:0]        cur_h;
    logic [3:0]        in_h;
    logic              hit_now;
    logic              last_dir;

    // Same-colour run length stepping away from (r,c), capped at 3 cells.
    function automatic logic [2:0] run_len(input logic [BW-1:0] b,
                                           input int r, input int c,
                                           input int dr, input int dc,
                                           input logic [1:0] pc);
        logic [2:0] n;
        logic       open;
        int         rr;
        int         cc;
        n    = '0;
        open = 1'b1;
        for (int unsigned k = 1; k <= 3; k++) begin
            rr = r + dr * int'(k);
            cc = c + dc * int'(k);
            if (open) begin
                if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) begin
                    if (b[(rr*COLS+cc)*2 +: 2] == pc) n = n + 3'd1;
                    else                              open = 1'b0;
                end else begin
                    open = 1'b0;
                end
            end
        end
        return n;
    endfunction

    function automatic logic line_hit(input logic [BW-1:0] b,
                                      input int r, input int c,
                                      input int dr, input int dc,
                                      input logic [1:0] pc);
        logic [3:0] total;
        total = 4'(run_len(b, r, c, dr, dc, pc)) +
                4'(run_len(b, r, c, -dr, -dc, pc)) + 4'd1;
        return total >= 4'd4;
    endfunction

    always_comb begin
        code       = player_q ? 2'b01 : 2'b10;
        dir_hit[0] = line_hit(board_q, int'(row_q), int'(col_q), 0, 1, code);  // horizontal
        dir_hit[1] = line_hit(board_q, int'(row_q), int'(col_q), 1, 0, code);  // vertical
        dir_hit[2] = line_hit(board_q, int'(row_q), int'(col_q), 1, 1, code);  // diagonal /
        dir_hit[3] = line_hit(board_q, int'(row_q), int'(col_q), 1, -1, code); // anti-diagonal
    end

    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        height_d = height_q;
        moves_d  = moves_q;
        col_d    = col_q;
        row_d    = row_q;
        player_d = player_q;
        acc_d    = acc_q;
        hit_d    = hit_q;
        dir_d    = dir_q;
        win_d    = win_q;
        winner_d = winner_q;
        full_d   = full_q;
        hit_now  = 1'b0;
        last_dir = 1'b0;
        cur_h    = height_q[int'(col_q)*4 +: 4];
        in_h     = '0;

        case (state_q)
            IDLE: begin
                if (move_valid) begin
                    col_d    = column;
                    player_d = player;
                    hit_d    = 1'b0;
                    dir_d    = '0;
                    if (int'(column) >= COLS) begin
                        acc_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        in_h = height_q[int'(column)*4 +: 4];
                        if (in_h == 4'(ROWS)) begin
                            acc_d   = 1'b0;
                            state_d = DONE;
                        end else begin
                            acc_d   = 1'b1;
                            state_d = DROP;
                        end
                    end
                end
            end
            DROP: begin
                board_d[(int'(cur_h)*COLS+int'(col_q))*2 +: 2] = code;
                row_d    = cur_h[2:0];
                height_d[int'(col_q)*4 +: 4] = cur_h + 4'd1;
                moves_d  = moves_q + CW'(1);
                state_d  = CHECK;
            end
            CHECK: begin
`ifdef BOARD_ENGINE_FAST_CHECK_EN
                hit_now  = |dir_hit;
                last_dir = 1'b1;
`else
                hit_now  = hit_q | dir_hit[dir_q];
                last_dir = (dir_q == 2'd3);
`endif
                hit_d = hit_now;
                dir_d = dir_q + 2'd1;
                // Flags are committed on the edge entering DONE so they
                // change together with the rising result_valid.
                if (last_dir) begin
                    state_d = DONE;
                    if (hit_now) begin
                        win_d    = 1'b1;
                        winner_d = code;
                    end else if (int'(moves_q) == CELLS) begin
                        full_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = (win_q || full_q) ? OVER : IDLE;
            end
            OVER: begin
                state_d = OVER;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            board_q  <= '0;
            height_q <= '0;
            moves_q  <= '0;
            col_q    <= '0;
            row_q    <= '0;
            player_q <= 1'b0;
            acc_q    <= 1'b0;
            hit_q    <= 1'b0;
            dir_q    <= '0;
            win_q    <= 1'b0;
            winner_q <= '0;
            full_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            height_q <= height_d;
            moves_q  <= moves_d;
            col_q    <= col_d;
            row_q    <= row_d;
            player_q <= player_d;
            acc_q    <= acc_d;
            hit_q    <= hit_d;
            dir_q    <= dir_d;
            win_q    <= win_d;
            winner_q <= winner_d;
            full_q   <= full_d;
        end
    end

    always_comb begin
        move_ready    = (state_q == IDLE);
        result_valid  = (state_q == DONE);
        move_accepted = (state_q == DONE) & acc_q;
        win           = win_q;
        winner        = winner_q;
        board_full    = full_q;
        rd_cell       = '0;
        if (int'(rd_row) < ROWS && int'(rd_col) < COLS)
            rd_cell = board_q[(int'(rd_row)*COLS+int'(rd_col))*2 +: 2];
    end

endmodule

// File: tb/tb_board_engine.sv
module tb_board_engine;

    localparam int ROWS = 6;
    localparam int COLS = 7;
`ifdef BOARD_ENGINE_FAST_CHECK_EN
    localparam int ACC_LAT = 3;
`else
    localparam int ACC_LAT = 6;
`endif

    logic       clk;
    logic       reset;
    logic       move_valid;
    logic       move_ready;
    logic [2:0] column;
    logic       player;
    logic       result_valid;
    logic       move_accepted;
    logic       win;
    logic [1:0] winner;
    logic       board_full;
    logic [2:0] rd_row;
    logic [2:0] rd_col;
    logic [1:0] rd_cell;

    board_engine #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .reset(reset), .move_valid(move_valid), .move_ready(move_ready),
        .column(column), .player(player), .result_valid(result_valid),
        .move_accepted(move_accepted), .win(win), .winner(winner),
        .board_full(board_full), .rd_row(rd_row), .rd_col(rd_col), .rd_cell(rd_cell)
    );

    typedef struct {
        logic       acc;
        logic       win;
        logic [1:0] winner;
        logic       full;
        int         h;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] model [0:7][0:7];
    int         mh [0:7];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        reset = 1'b1;
        move_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int r = 0; r < 8; r++) begin
            mh[r] = 0;
            for (int c = 0; c < 8; c++) model[r][c] = 2'b00;
        end
        sb.delete();
    endtask

    task automatic check_board(input string nm);
        logic [1:0] e;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                rd_row = 3'(r);
                rd_col = 3'(c);
                #1;
                e = (r < ROWS && c < COLS) ? model[r][c] : 2'b00;
                n_cmp++;
                if (rd_cell !== e) begin
                    n_bad++;
                    $display("FAIL %s rd_cell(%0d,%0d): got %b want %b", nm, r, c, rd_cell, e);
                end
            end
        end
    endtask

    // Drives one handshake, pushes the expected result, and pops/compares
    // it when result_valid appears.
    task automatic send_move(input int col, input logic pl, input logic acc,
                             input logic ew, input logic [1:0] ewn, input logic ef);
        exp_t e;
        exp_t o;
        bit   got;
        int   lat;
        @(negedge clk);
        n_cmp++;
        if (move_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_pre col%0d: got %b want 1", col, move_ready);
        end
        column = 3'(col);
        player = pl;
        move_valid = 1'b1;
        e.acc = acc; e.win = ew; e.winner = ewn; e.full = ef; e.h = cyc;
        sb.push_back(e);
        if (acc) begin
            model[mh[col]][col] = pl ? 2'b01 : 2'b10;
            mh[col]++;
        end
        @(posedge clk);
        #1 move_valid = 1'b0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1) begin
                got = 1;
                o = sb.pop_front();
                lat = cyc - o.h;
                n_cmp++;
                if (move_accepted !== o.acc) begin
                    n_bad++;
                    $display("FAIL accepted col%0d: got %b want %b", col, move_accepted, o.acc);
                end
                n_cmp++;
                if (win !== o.win) begin
                    n_bad++;
                    $display("FAIL win col%0d: got %b want %b", col, win, o.win);
                end
                n_cmp++;
                if (winner !== o.winner) begin
                    n_bad++;
                    $display("FAIL winner col%0d: got %b want %b", col, winner, o.winner);
                end
                n_cmp++;
                if (board_full !== o.full) begin
                    n_bad++;
                    $display("FAIL board_full col%0d: got %b want %b", col, board_full, o.full);
                end
                n_cmp++;
                if (lat != (o.acc ? ACC_LAT : 1)) begin
                    n_bad++;
                    $display("FAIL latency col%0d: got %0d want %0d", col, lat, o.acc ? ACC_LAT : 1);
                end
            end
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL result_timeout col%0d: got none want result_valid", col);
        end
        @(negedge clk);
        n_cmp++;
        if (result_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL pulse_width col%0d: got %b want 0", col, result_valid);
        end
        n_cmp++;
        if (move_ready !== !(ew | ef)) begin
            n_bad++;
            $display("FAIL ready_post col%0d: got %b want %b", col, move_ready, !(ew | ef));
        end
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_cmp++;
        if ({move_ready, result_valid, move_accepted, win, winner, board_full} !== 7'b1000000) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 1000000",
                     {move_ready, result_valid, move_accepted, win, winner, board_full});
        end
        check_board("reset");
    endtask

    task automatic test_vertical_win();
        int seen;
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            send_move(i % 2, (i % 2) == 0, 1'b1, i == 6, (i == 6) ? 2'b01 : 2'b00, 1'b0);
        end
        check_board("vertical");
        @(negedge clk);
        column = 3'd3;
        player = 1'b1;
        move_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (result_valid !== 1'b0) seen++;
        end
        move_valid = 1'b0;
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL over_ignored: got %0d results want 0", seen);
        end
        n_cmp++;
        if ({move_ready, win, winner} !== 4'b0101) begin
            n_bad++;
            $display("FAIL over_hold: got %b want 0101", {move_ready, win, winner});
        end
        check_board("over");
    endtask

    task automatic test_reject();
        logic pls [0:5];
        pls = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        apply_reset();
        for (int i = 0; i < 6; i++) send_move(2, pls[i], 1'b1, 1'b0, 2'b00, 1'b0);
        send_move(2, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        send_move(7, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        check_board("reject");
        send_move(3, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
        check_board("after_reject");
    endtask

    // Entries are col*2+player; the last entry of each sequence wins for P2.
    task automatic test_lines();
        int seq [0:2][0:9];
        int len [0:2];
        seq = '{'{0, 3, 2, 5, 5, 4, 7, 6, 7, 6},
                '{12, 11, 10, 9, 9, 8, 7, 6, 7, 6},
                '{6, 1, 8, 1, 10, 1, 12, 0, 0, 0}};
        len = '{10, 10, 7};
        for (int s = 0; s < 3; s++) begin
            apply_reset();
            for (int i = 0; i < len[s]; i++) begin
                send_move(seq[s][i] / 2, seq[s][i] % 2 == 1, 1'b1,
                          i == len[s] - 1, (i == len[s] - 1) ? 2'b10 : 2'b00, 1'b0);
            end
            check_board("line");
        end
    endtask

    // Colour = ((c>>1)&1) ^ (r&1): runs never exceed 2 in any direction.
    task automatic test_full();
        logic pl;
        apply_reset();
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                pl = ((c >> 1) & 1) != (r & 1);
                send_move(c, pl, 1'b1, 1'b0, 2'b00, (c == COLS - 1) && (r == ROWS - 1));
            end
        end
        check_board("full");
    endtask

    task automatic test_reset_mid();
        int seen;
        apply_reset();
        @(negedge clk);
        column = 3'd4;
        player = 1'b1;
        move_valid = 1'b1;
        @(posedge clk);
        #1 move_valid = 1'b0;
        @(posedge clk);
        #2;
        rd_row = 3'd0;
        rd_col = 3'd4;
        #1;
        n_cmp++;
        if (rd_cell !== 2'b01) begin
            n_bad++;
            $display("FAIL mid_written: got %b want 01", rd_cell);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({result_valid, rd_cell, move_ready} !== 4'b0001) begin
            n_bad++;
            $display("FAIL mid_in_reset: got %b want 0001", {result_valid, rd_cell, move_ready});
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (result_valid !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL mid_discard: got %0d results want 0", seen);
        end
        n_cmp++;
        if (move_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_ready: got %b want 1", move_ready);
        end
        for (int r = 0; r < 8; r++) begin
            mh[r] = 0;
            for (int c = 0; c < 8; c++) model[r][c] = 2'b00;
        end
        check_board("mid_reset");
        send_move(4, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0);
        check_board("post_mid");
    endtask

    initial begin
        reset = 1'b1;
        move_valid = 1'b0;
        column = '0;
        player = 1'b0;
        rd_row = '0;
        rd_col = '0;
        test_reset();
        test_vertical_win();
        test_reject();
        test_lines();
        test_full();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/board_engine.md
# board_engine

Responder side of the move interface: owns the Connect Four board, accepts one move request at a time from the turn controller, drops the piece into the chosen column, checks for four-in-a-row around the placed piece, and returns a one-cycle result. Also exposes a read port for the display path. Sits between the turn controller (initiator) and the VGA renderer.

## Interface
- ROWS, 6, board height (max 8); row 0 is the bottom row.
- COLS, 7, board width (max 8).
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- move_valid  in  1  move request; sampled only while move_ready=1.
- move_ready  out  1  engine idle and accepting requests.
- column  in  3  target column, sampled at handshake.
- player  in  1  1 = player 1, 0 = player 2; sampled at handshake.
- result_valid  out  1  one-cycle pulse closing each accepted handshake.
- move_accepted  out  1  valid with result_valid; 0 = column full or column >= COLS.
- win  out  1  sticky once a four-in-a-row is found.
- winner  out  2  00 none, 01 player 1, 10 player 2; sticky.
- board_full  out  1  sticky; all ROWS*COLS cells filled with no win (draw).
- rd_row  in  3, rd_col  in  3  display read address.
- rd_cell  out  2  combinational cell contents: 00 empty, 01 P1, 10 P2; 00 for out-of-range address.

## Operation
- Storage: ROWS*COLS 2-bit cells, per-column height counters (0..ROWS), move counter (0..ROWS*COLS).
- States: IDLE, DROP, CHECK, DONE, OVER.
- IDLE: move_ready=1. On move_valid: latch column/player. If column >= COLS or height[column]==ROWS -> DONE with move_accepted=0, board untouched. Else -> DROP.
- DROP: write player code to (height[col], col); latch placed row; height[col]+1; move counter +1 -> CHECK.
- CHECK: one direction per cycle in order horizontal, vertical, diagonal (/), anti-diagonal (\). For each, count contiguous same-colour cells on both sides of the placed cell, at most 3 per side, stopping at board edge or other colour. Total including placed cell >= 4 sets internal hit. Remaining directions still evaluated (fixed latency). -> DONE.
- DONE: result_valid=1, move_accepted as determined. If hit: win=1, winner=player code, -> OVER. Else if move counter==ROWS*COLS: board_full=1, -> OVER. Else -> IDLE.
- OVER: move_ready=0; move_valid ignored; board and flags held until reset.
- move_valid while move_ready=0 is ignored, not queued.
- Rejected moves never change board, heights, or move counter.
- Win and draw on the same move: win takes precedence; board_full stays 0.

## Timing
- Reset values: move_ready=1, result_valid=0, move_accepted=0, win=0, winner=00, board_full=0, all cells 00, state IDLE.
- Handshake at edge E0 (move_valid & move_ready). Accepted move: DROP after E0, CHECK E1..E4, result_valid high for cycle after E5; move_ready returns after E6 (unless OVER).
- Rejected move: result_valid high for cycle after E0; move_ready returns after E1.
- rd_cell reflects a DROP write from the cycle after the write edge.
- win, winner, board_full change at the same edge that raises result_valid.
- Reset mid-operation: board cleared, pending result discarded, no result_valid.

## Configuration
- BOARD_ENGINE_FAST_CHECK_EN defined: CHECK evaluates all four directions combinationally in a single cycle; accepted-move result_valid after E2 (latency 3 edges incl. DONE).
- Undefined: sequential four-cycle CHECK as above. Rejected-move latency identical in both builds.

## Test plan
- Reset -> move_ready=1, win=0, winner=00, board_full=0, rd_cell=00 at every address.
- P1 col 0, P2 col 1 alternating, 7 moves -> 7th result_valid with move_accepted=1, win=1, winner=01, move_ready=0; further move_valid gives no result_valid.
- Six moves into col 2, seventh into col 2 and one into col 7 -> each result_valid with move_accepted=0, one cycle after handshake; rd_cell unchanged.
- Build staircase so P2 completes (0,0),(1,1),(2,2),(3,3) -> winner=10; repeat for anti-diagonal and horizontal (row 0, cols 3..6).
- Fill all 42 cells in a no-win pattern -> last result_valid with board_full=1, win=0, move_ready=0.
- Assert reset during CHECK -> no result_valid, all cells 00, move_ready=1 after release; check latencies in both macro builds.
